// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Round-robin arbiter that merges NUM_REQ packet streams into the write port of
// a single FIFO. Requesters compete in IDLE; the winner owns the FIFO write port
// in BURST until it sends its last beat, reaches MAX_BURST beats, or drops valid.
//
// Handshake (valid/ready), applies to every requester i:
//   - A beat transfers in a cycle where req_valid[i] && req_ready[i] are both
//     high at the rising clock edge; that same cycle drives fifo_wr_en.
//   - req_ready[i] is combinational: it is high only for the current grantee,
//     only in BURST, and only while the FIFO is not full. It does not depend
//     on req_valid[i], so a requester may look at ready before raising valid.
//   - A requester may drop req_valid at any time; doing so while granted
//     releases the grant on the next edge.
//
// Ports:
//   clk            FIFO write-side clock, all state updates on rising edge
//   rst_n          synchronous active-low reset
//   req_valid      per-requester beat valid
//   req_data       packed per-requester data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_last       per-requester end-of-packet marker
//   req_ready      per-requester beat accept (combinational)
//   fifo_full      FIFO full flag (write-clock synchronous)
//   fifo_wr_en     FIFO write enable (combinational)
//   fifo_wr_data   FIFO write data, zero when no write
//   grant_id       index of the current or most recent grantee
//   busy           high while in BURST
//   dbg_state      raw FSM state (0 = IDLE, 1 = BURST)
//   dbg_beat_cnt   beats accepted in the current/most recent burst
//   dbg_last_grant grantee of the most recently completed burst
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_REQ-1:0]                 req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]      req_data,
  input  logic [NUM_REQ-1:0]                 req_last,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic                               fifo_full,
  output logic                               fifo_wr_en,
  output logic [DATA_WIDTH-1:0]              fifo_wr_data,
  output logic [$clog2(NUM_REQ)-1:0]         grant_id,
  output logic                               busy,
  output logic                               dbg_state,
  output logic [$clog2(MAX_BURST+1)-1:0]     dbg_beat_cnt,
  output logic [$clog2(NUM_REQ)-1:0]         dbg_last_grant
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   last_grant_q, last_grant_d;
  logic [BW-1:0]   beat_cnt_q, beat_cnt_d;

  // ---------------------------------------------------------------------------
  // Round-robin search: first valid requester starting at last_grant+1.
  // ---------------------------------------------------------------------------
  logic [GW-1:0] rr_pick;
  logic          rr_found;

  always_comb begin : rr_search
    int            idx;
    logic [GW-1:0] cand;
    idx      = 0;
    cand     = '0;
    rr_pick  = last_grant_q;
    rr_found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx  = (int'(last_grant_q) + k) % NUM_REQ;
      cand = GW'(idx);
      if (!rr_found && req_valid[cand]) begin
        rr_pick  = cand;
        rr_found = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Grantee view: valid/last/data of the requester selected by grant_q.
  // ---------------------------------------------------------------------------
  logic                  g_valid;
  logic                  g_last;
  logic [DATA_WIDTH-1:0] g_data;

  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == GW'(i)) begin
        g_valid = req_valid[i];
        g_last  = req_last[i];
        g_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Write path. rst_n gates the write so a burst interrupted by reset never
  // writes in the reset cycle itself; the requester sees ready low and keeps
  // its beat, so nothing is lost.
  // ---------------------------------------------------------------------------
  logic          in_burst;
  logic          can_write;
  logic          accept;
  logic [BW-1:0] beat_inc;
  logic          cap_hit;

  always_comb begin
    in_burst  = (state_q == ST_BURST);
    can_write = rst_n && in_burst && !fifo_full;
    accept    = can_write && g_valid;
    beat_inc  = beat_cnt_q + BW'(1);
    cap_hit   = (beat_inc == BW'(MAX_BURST));
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = can_write && (grant_q == GW'(i));
    end
  end

  always_comb begin
    fifo_wr_en   = accept;
    fifo_wr_data = accept ? g_data : '0;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic.
  //   IDLE : any valid -> latch round-robin winner, clear beat count, BURST.
  //   BURST: grantee drops valid      -> IDLE (no beat).
  //          FIFO full, grantee valid -> hold (no timeout, count holds).
  //          beat accepted            -> count; last beat or cap -> IDLE.
  // Every exit records the grantee as last_grant for the next search.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (rr_found) begin
          grant_d    = rr_pick;
          beat_cnt_d = '0;
          state_d    = ST_BURST;
        end
      end

      ST_BURST: begin
        if (!g_valid) begin
          state_d      = ST_IDLE;
          last_grant_d = grant_q;
        end else if (accept) begin
          beat_cnt_d = beat_inc;
          if (g_last || cap_hit) begin
            state_d      = ST_IDLE;
            last_grant_d = grant_q;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers. last_grant resets to NUM_REQ-1 so requester 0 wins the
  // first arbitration after reset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(NUM_REQ - 1);
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Status / debug outputs.
  // ---------------------------------------------------------------------------
  always_comb begin
    grant_id       = grant_q;
    busy           = in_burst;
    dbg_state      = state_q;
    dbg_beat_cnt   = beat_cnt_q;
    dbg_last_grant = last_grant_q;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of one data word; SHALL match the DATA_WIDTH of the FIFO write port it drives.
REQ-002 Parameter NUM_REQ, default 4: number of requesters; legal range 2..16.
REQ-003 Parameter MAX_BURST, default 4: maximum beats per grant; legal range 1..256.
REQ-004 Port clk, input, 1: single clock, the FIFO write-side clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1: reset, synchronous and active-low.
REQ-006 Port req_valid, input, NUM_REQ: bit i high means requester i presents a beat.
REQ-007 Port req_data, input, NUM_REQ*DATA_WIDTH: requester i data is in slice [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 Port req_last, input, NUM_REQ: bit i marks the final beat of requester i's packet.
REQ-009 Port req_ready, output, NUM_REQ: bit i high means requester i's beat is accepted this cycle.
REQ-010 Port fifo_full, input, 1: FIFO full flag, write-domain synchronous.
REQ-011 Port fifo_wr_en, output, 1: FIFO write enable.
REQ-012 Port fifo_wr_data, output, DATA_WIDTH: FIFO write data.
REQ-013 Port grant_id, output, $clog2(NUM_REQ): index of the current or most recent grantee.
REQ-014 Port busy, output, 1: high while in state BURST.

Function
REQ-015 The FSM SHALL have two states, IDLE and BURST.
REQ-016 IDLE, any req_valid high: on the next edge, register grant_id as the first valid index searching round-robin from last_grant+1 (mod NUM_REQ), clear beat_cnt, go to BURST.
REQ-017 IDLE, no req_valid high: stay in IDLE; grant_id holds its value.
REQ-018 The arbiter SHALL NOT accept a beat in IDLE; arbitration latency is exactly 1 cycle from valid to first possible accept.
REQ-019 BURST: req_ready[grant_id] = !fifo_full (combinational); all other req_ready bits SHALL be 0.
REQ-020 Beat accepted when req_valid[grant_id] && req_ready[grant_id]; in that cycle fifo_wr_en = 1 and fifo_wr_data = the grantee's req_data slice, both combinational.
REQ-021 fifo_wr_en SHALL never be high while fifo_full is high; nothing is lost or duplicated.
REQ-022 beat_cnt, $clog2(MAX_BURST+1) bits, SHALL increment on each accepted beat.
REQ-023 BURST exits to IDLE on the edge after an accepted beat with req_last[grant_id]=1, or after the accepted beat that makes beat_cnt equal MAX_BURST.
REQ-024 BURST, req_valid[grant_id]=0: exit to IDLE on the next edge (grant released, no beat).
REQ-025 BURST, fifo_full=1 with grantee valid: stay in BURST indefinitely; no timeout; beat_cnt holds.
REQ-026 On every exit from BURST, last_grant SHALL be set to grant_id.
REQ-027 A full-triggered exit and a req_last exit in the same cycle cannot occur (a full FIFO accepts no beat); req_last together with beat_cnt reaching MAX_BURST is one exit.
REQ-028 Requests from other requesters arriving during BURST SHALL be held off (ready 0) until the next IDLE arbitration.

Reset
REQ-029 With rst_n=0 at a rising edge: state=IDLE, beat_cnt=0, grant_id=0, last_grant=NUM_REQ-1 (so requester 0 has first priority).
REQ-030 While in reset state: req_ready=0, fifo_wr_en=0, fifo_wr_data=0, busy=0.
REQ-031 Reset asserted mid-BURST SHALL abort the burst at that edge with no further FIFO write.

Verification
REQ-032 Single requester: req_valid=0001, 3 beats, last on beat 3, full=0 -> grant_id=0; writes on cycles 2,3,4 after valid; busy falls after beat 3.
REQ-033 Burst cap: MAX_BURST=4, requester 1 streams 10 beats, no last -> 4 writes, then IDLE, re-grant to 1 (sole requester); every fourth accepted beat is followed by a 1-cycle bubble.
REQ-034 Round-robin: all four valid continuously -> grant order 0,1,2,3,0; each burst is at most MAX_BURST beats.
REQ-035 Backpressure: fifo_full=1 for 5 cycles mid-burst -> fifo_wr_en=0 and req_ready=0 throughout; beat_cnt unchanged; data order intact after release.
REQ-036 Valid drop: grantee deasserts valid mid-burst -> IDLE next edge; last_grant updated; next valid requester is granted.
REQ-037 Reset mid-burst: rst_n=0 for 1 cycle during beat 2 -> next cycle all outputs 0, state IDLE, requester 0 has priority.
